// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite DMA sequencer that stalls the CPU and copies a 256-byte page into OAM
module oam_dma_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR = 16'h4014,
  parameter int XFER_LEN = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [REG_WIDTH-1:0]  cpu_din,
  input  logic                  cpu_we,
  output logic                  cpu_rdy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_din,
  output logic                  mem_we,
  input  logic [REG_WIDTH-1:0]  mem_dout,
  output logic [7:0]            oam_addr,
  output logic [REG_WIDTH-1:0]  oam_data,
  output logic                  oam_we,
  output logic                  busy
);
  localparam logic [2:0] IDLE = 3'd0, HALT = 3'd1, ALIGN = 3'd2, READ = 3'd3, WRITE = 3'd4;
  logic [2:0] state, nxt;
  logic parity, trig, idle, wr;
  logic [7:0] page, idx, oam_addr_q;
  logic [REG_WIDTH-1:0] oam_data_q;
  assign idle = state == IDLE;
  assign wr = state == WRITE;
  assign trig = idle && cpu_we && cpu_addr == TRIGGER_ADDR;
  always_comb
    nxt = idle ? (trig ? HALT : IDLE) :
          state == HALT ? (parity ? ALIGN : READ) :
          state == ALIGN ? READ :
          state == READ ? WRITE :
          wr ? (idx == 8'(XFER_LEN - 1) ? IDLE : READ) : IDLE;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      parity <= 1'b0;
      idx <= '0;
      page <= '0;
      oam_addr_q <= '0;
      oam_data_q <= '0;
    end else begin
      state <= nxt;
      parity <= ~parity;
      if (trig) begin
        page <= cpu_din[7:0];
        idx <= '0;
      end
      if (wr) begin
        idx <= idx + 8'd1;
        oam_addr_q <= idx;
        oam_data_q <= mem_dout;
      end
    end
  assign cpu_rdy = idle;
  assign busy = !idle;
  // During a transfer the memory port belongs to the DMA; CPU writes are dropped
  assign mem_addr = idle ? cpu_addr : ADDR_WIDTH'({page, idx});
  assign mem_din = cpu_din;
  assign mem_we = idle && cpu_we && !trig;
  assign oam_we = wr;
  assign oam_addr = wr ? idx : oam_addr_q;
  assign oam_data = wr ? mem_dout : oam_data_q;
endmodule
